// File: rtl/prop_eller_pkg.sv
// Shared types and helpers for the preceded_by_window past-time checker.
package prop_eller_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WARMUP   = 2'd1,
        CHECKING = 2'd2
    } chk_state_t;

    localparam int MAX_HIST = 32;

    // Increment value, holding at the all-ones value of a width-bit counter.
    function automatic logic [MAX_HIST-1:0] sat_inc(input logic [MAX_HIST-1:0] value,
                                                    input int unsigned width);
        logic [MAX_HIST-1:0] max_v;
        max_v = {MAX_HIST{1'b1}} >> (MAX_HIST - width);
        if (value >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/event_history.sv
// Shift register of past precond samples plus the OR over the accepted window.
module event_history
    import prop_eller_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    output logic [MAX_DLY:1] hist,
    output logic             hit
);

    logic [MAX_DLY:1] hist_r;
    logic             hit_s;

    // hist_r[k] holds din sampled k edges ago; clr flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= '0;
        end else if (clr) begin
            hist_r <= '0;
        end else begin
            hist_r[1] <= din;
            for (int k = 2; k <= MAX_DLY; k++) begin
                hist_r[k] <= hist_r[k-1];
            end
        end
    end

    // Window hit uses the pre-shift contents, so a same-edge din never qualifies.
    always_comb begin
        hit_s = 1'b0;
        for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
            hit_s = hit_s | hist_r[k];
        end
    end

    assign hist = hist_r;
    assign hit  = hit_s;

endmodule

// File: rtl/preceded_by_window.sv
// Past-time checker: every prop must follow a precond by MIN_DLY..MAX_DLY cycles.
// Optional macro PRECEDED_BY_WINDOW_PASS_CNT_EN adds the pass_count output.
module preceded_by_window
    import prop_eller_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_cond,
    input  logic             precond,
    input  logic             prop,
    output logic             sample,
    output logic             fail,
    output logic             fail_seen,
    output logic [CNT_W-1:0] fail_count
`ifdef PRECEDED_BY_WINDOW_PASS_CNT_EN
    ,
    output logic [CNT_W-1:0] pass_count
`endif
);

    localparam int WCNT_W = $clog2(MAX_HIST);

    if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > MAX_HIST ||
        CNT_W < 1 || CNT_W > MAX_HIST) begin : g_bad_cfg
        $error("preceded_by_window: illegal MIN_DLY/MAX_DLY/CNT_W combination");
    end

    chk_state_t        state_r, next_state_s;
    logic [WCNT_W-1:0] warm_cnt_r, next_cnt_s;
    logic [MAX_DLY:1]  hist_s;
    logic              hit_s;
    logic              sample_s, fail_s;
    logic              unused_s;

    event_history #(
        .MIN_DLY (MIN_DLY),
        .MAX_DLY (MAX_DLY)
    ) u_history (
        .clk  (clk),
        .rst  (rst),
        .clr  (~enable_cond),
        .din  (precond),
        .hist (hist_s),
        .hit  (hit_s)
    );

    // The raw history vector is exported for probing; only the window OR drives decisions.
    assign unused_s = ^hist_s;

    // State and warm-up counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= DISABLED;
            warm_cnt_r <= '0;
        end else begin
            state_r    <= next_state_s;
            warm_cnt_r <= next_cnt_s;
        end
    end

    // Next state and the pass/fail decision for the prop sampled at this edge.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = warm_cnt_r;
        sample_s     = 1'b0;
        fail_s       = 1'b0;
        if (!enable_cond) begin
            next_state_s = DISABLED;
            next_cnt_s   = '0;
        end else begin
            case (state_r)
                DISABLED: begin
                    next_state_s = WARMUP;
                    next_cnt_s   = '0;
                end
                WARMUP: begin
                    sample_s = prop & hit_s;
                    if (warm_cnt_r == WCNT_W'(MAX_DLY - 1)) begin
                        next_state_s = CHECKING;
                    end else begin
                        next_cnt_s = warm_cnt_r + WCNT_W'(1'b1);
                    end
                end
                CHECKING: begin
                    sample_s = prop & hit_s;
                    fail_s   = prop & ~hit_s;
                end
                default: begin
                    next_state_s = DISABLED;
                    next_cnt_s   = '0;
                end
            endcase
        end
    end

    // Registered pulses, sticky flag and saturating failure counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample     <= 1'b0;
            fail       <= 1'b0;
            fail_seen  <= 1'b0;
            fail_count <= '0;
        end else begin
            sample <= sample_s;
            fail   <= fail_s;
            if (fail_s) begin
                fail_seen  <= 1'b1;
                fail_count <= CNT_W'(sat_inc(MAX_HIST'(fail_count), CNT_W));
            end
        end
    end

`ifdef PRECEDED_BY_WINDOW_PASS_CNT_EN
    // Saturating count of pass pulses, so vacuous runs are visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
        end else if (sample_s) begin
            pass_count <= CNT_W'(sat_inc(MAX_HIST'(pass_count), CNT_W));
        end
    end
`endif

endmodule

// File: tb/tb_preceded_by_window.sv
// Randomized bench for preceded_by_window against a run-length/history reference model.
module tb_preceded_by_window;

    localparam int P_MIN   = 2;
    localparam int P_MAX   = 5;
    localparam int P_CNT   = 3;
    localparam int CNT_MAX = (1 << P_CNT) - 1;

    logic             clk, rst, enable_cond, precond, prop;
    logic             sample, fail, fail_seen;
    logic [P_CNT-1:0] fail_count;
`ifdef PRECEDED_BY_WINDOW_PASS_CNT_EN
    logic [P_CNT-1:0] pass_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Reference model state: consecutive enabled edges and precond history by age.
    int        run_n;
    bit [63:0] pc_q;
    bit        exp_sample, exp_fail, exp_seen;
    int        exp_cnt, exp_pass;

    preceded_by_window #(.MIN_DLY(P_MIN), .MAX_DLY(P_MAX), .CNT_W(P_CNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_cond (enable_cond),
        .precond     (precond),
        .prop        (prop),
        .sample      (sample),
        .fail        (fail),
        .fail_seen   (fail_seen),
        .fail_count  (fail_count)
`ifdef PRECEDED_BY_WINDOW_PASS_CNT_EN
        ,
        .pass_count  (pass_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // A precond k edges ago qualifies if it is within the window and no disable intervened.
    function automatic bit model_hit();
        bit h = 1'b0;
        for (int k = P_MIN; k <= P_MAX; k++) begin
            if (k <= run_n && pc_q[k]) h = 1'b1;
        end
        return h;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_n <= 0; pc_q <= '0;
            exp_sample <= 1'b0; exp_fail <= 1'b0; exp_seen <= 1'b0;
            exp_cnt <= 0; exp_pass <= 0;
        end else begin
            exp_sample <= enable_cond && prop && model_hit();
            exp_fail   <= enable_cond && (run_n > P_MAX) && prop && !model_hit();
            if (enable_cond && (run_n > P_MAX) && prop && !model_hit()) begin
                exp_seen <= 1'b1;
                if (exp_cnt < CNT_MAX) exp_cnt <= exp_cnt + 1;
            end
            if (enable_cond && prop && model_hit() && exp_pass < CNT_MAX) exp_pass <= exp_pass + 1;
            if (enable_cond) begin
                run_n <= (run_n < 1000) ? run_n + 1 : run_n;
                pc_q  <= (pc_q << 1) | (64'(precond) << 1);
            end else begin
                run_n <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("sample", int'(sample), int'(exp_sample));
            check("fail", int'(fail), int'(exp_fail));
            check("fail_seen", int'(fail_seen), int'(exp_seen));
            check("fail_count", int'(fail_count), exp_cnt);
            check("exclusive", int'(sample & fail), 0);
`ifdef PRECEDED_BY_WINDOW_PASS_CNT_EN
            check("pass_count", int'(pass_count), exp_pass);
`endif
        end
    end

    task automatic step(input bit en, input bit pc, input bit pr);
        @(negedge clk);
        enable_cond = en; precond = pc; prop = pr;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int s, input int f, input int c);
        check({name, ".sample"}, int'(sample), s);
        check({name, ".fail"}, int'(fail), f);
        check({name, ".count"}, int'(fail_count), c);
    endtask

    initial begin
        rst = 1'b1; enable_cond = 1'b0; precond = 1'b0; prop = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.sample", int'(sample), 0);
        check("reset.fail_seen", int'(fail_seen), 0);
        check("reset.fail_count", int'(fail_count), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Warm up, then a pass at distance 3.
        repeat (7) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        lit("dist3", 1, 0, 0);
        // Distance MAX+1 fails.
        step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        lit("dist6", 0, 1, 1);
        check("dist6.seen", int'(fail_seen), 1);
        // Same edge and distance 1 are below MIN; distance 2 passes.
        step(1'b1, 1'b1, 1'b1);
        lit("same_edge", 0, 1, 2);
        step(1'b1, 1'b0, 1'b1);
        lit("dist1", 0, 1, 3);
        step(1'b1, 1'b0, 1'b1);
        lit("dist2", 1, 0, 3);
        // Exactly MAX passes.
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        lit("dist5", 1, 0, 3);
        // Enable low pulse: unmatched props in warm-up are vacuous, matched ones pass.
        step(1'b0, 1'b0, 1'b0);
        lit("disabled", 0, 0, 3);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        lit("warmup_vac", 0, 0, 3);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        lit("warmup_pass", 1, 0, 3);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        lit("recheck_fail", 0, 1, 4);
`ifdef PRECEDED_BY_WINDOW_PASS_CNT_EN
        check("pass_count.lit", int'(pass_count), 4);
`endif
        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2 rst = 1'b1;
        #1;
        lit("async_rst", 0, 0, 0);
        check("async_rst.seen", int'(fail_seen), 0);
        @(negedge clk); rst = 1'b0;

        // Saturation: nine unmatched props in CHECKING.
        repeat (7) step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0, 1'b1);
        lit("saturate", 0, 1, CNT_MAX);

        // Randomized traffic with occasional disable and mid-cycle reset.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 31) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
